// File: rtl/lcd_cmd_issuer_pkg.sv
// Shared types for the LCD command issuer: command codes and issuer FSM states.
package lcd_cmd_issuer_pkg;

  typedef enum logic [2:0] {
    CMD_WRITE    = 3'd0,
    CMD_UP       = 3'd1,
    CMD_DOWN     = 3'd2,
    CMD_LEFT     = 3'd3,
    CMD_RIGHT    = 3'd4,
    CMD_AVERAGE  = 3'd5,
    CMD_MIRROR_X = 3'd6,
    CMD_MIRROR_Y = 3'd7
  } cmd_e;

  typedef enum logic [2:0] {
    StIdle,
    StIssue,
    StGap,
    StDrain,
    StFinish
  } state_e;

endpackage

// File: rtl/lcd_cmd_issuer_cmd_fifo.sv
// Command FIFO: power-of-two depth, pointers wrap naturally, drops push when full.
module cmd_fifo
  import lcd_cmd_issuer_pkg::*;
#(
  parameter int unsigned DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  cmd_e                     wdata,
  output cmd_e                     rdata,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] FullCnt = (AW + 1)'(DEPTH);

  cmd_e            mem [DEPTH];
  logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [AW:0]     count_q;
  logic            do_push, do_pop;

  assign full    = (count_q == FullCnt);
  assign empty   = (count_q == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign count   = count_q;
  assign rdata   = mem[rd_ptr_q];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      if (do_push && !do_pop)      count_q <= count_q + 1'b1;
      else if (!do_push && do_pop) count_q <= count_q - 1'b1;
    end
  end

  // Storage needs no reset; the issuer gates the head onto cmd only in StIssue.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/lcd_cmd_issuer.sv
// Queues LCD commands and issues them one at a time to the image controller.
// Optional sticky drop/protocol error flag: define LCD_CMD_ISSUER_ERRCHK_EN.
module lcd_cmd_issuer
  import lcd_cmd_issuer_pkg::*;
#(
  parameter int unsigned DEPTH = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    push,
  input  logic [2:0]              push_cmd,
  output logic                    full,
  output logic [$clog2(DEPTH):0]  count,
  input  logic                    busy,
  input  logic                    done,
  output logic [2:0]              cmd,
  output logic                    cmd_valid,
  output logic                    finished
`ifdef LCD_CMD_ISSUER_ERRCHK_EN
  ,
  output logic                    err
`endif
);

  state_e state_q, state_d;
  logic   wr_queued_q;
  logic   accept;
  logic   pop;
  logic   empty;
  cmd_e   head;

  // Once a write-out is queued the session is closed to new commands.
  assign accept = push && !full && !wr_queued_q;
  assign pop    = (state_q == StIssue);

  cmd_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk  (clk),
    .reset(reset),
    .push (accept),
    .pop  (pop),
    .wdata(cmd_e'(push_cmd)),
    .rdata(head),
    .count(count),
    .full (full),
    .empty(empty)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      wr_queued_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept && (cmd_e'(push_cmd) == CMD_WRITE)) wr_queued_q <= 1'b1;
    end
  end

  always_comb begin
    state_d   = state_q;
    cmd_valid = 1'b0;
    cmd       = 3'd0;
    finished  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (!empty && !busy) state_d = StIssue;
      end
      StIssue: begin
        cmd_valid = 1'b1;
        cmd       = head;
        state_d   = (head == CMD_WRITE) ? StDrain : StGap;
      end
      // GAP hands back to IDLE, applying IDLE's issue test on the same edge so
      // back-to-back commands keep a two-cycle cadence.
      StGap: begin
        state_d = (!empty && !busy) ? StIssue : StIdle;
      end
      StDrain: begin
        if (done) state_d = StFinish;
      end
      StFinish: begin
        finished = 1'b1;
      end
      default: state_d = StIdle;
    endcase
  end

`ifdef LCD_CMD_ISSUER_ERRCHK_EN
  logic err_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_q <= 1'b0;
    end else if ((push && (full || wr_queued_q)) || (done && (state_q != StDrain))) begin
      err_q <= 1'b1;
    end
  end

  assign err = err_q;
`endif

endmodule
